sobel_conv: RTL and testbench

- 3x3 Sobel edge-detection stage directly downstream of the line-buffer/window controller.
- Consumes the 72-bit window plus its valid and emits one 8-bit gradient-magnitude pixel per valid window, optionally binarised against a threshold.
- Fixed-latency 3-stage pipeline with no back-pressure; counts output pixels per image line and flags line completion for the DMA/interrupt logic.

---
 rtl/sobel_conv.sv | 104 ++++++++++
 tb/tb_sobel_conv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_conv.sv
// 3x3 Sobel gradient-magnitude stage: three-cycle fixed-latency pipeline with no stall.
// Each valid window produces one saturated or thresholded 8-bit pixel; o_line_done pulses at the end of each line.
module sobel_conv #(
    parameter int LINE_PIXELS = 512,
    parameter int CNT_W       = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [71:0] i_pixel_data,
    input  logic        i_pixel_data_valid,
    input  logic        i_bin_en,
    input  logic [7:0]  i_threshold,
    output logic [7:0]  o_convolved_data,
    output logic        o_convolved_data_valid,
    output logic        o_line_done
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_PIXELS - 1);

    logic [7:0]       p [0:8];
    logic [9:0]       px_d, nx_d, py_d, ny_d;
    logic [9:0]       px_q, nx_q, py_q, ny_q;
    logic signed [10:0] gx, gy;
    logic [9:0]       ax_d, ay_d, ax_q, ay_q;
    logic [10:0]      mag;
    logic [7:0]       sat, result;
    logic [1:0]       valid_sr;
    logic [CNT_W-1:0] col_cnt;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            p[k] = i_pixel_data[8*k +: 8];
        end
    end

    // Stage 1: the four weighted column/row sums, each at most 4*255
    always_comb begin
        px_d = {2'b00, p[2]} + {1'b0, p[5], 1'b0} + {2'b00, p[8]};
        nx_d = {2'b00, p[0]} + {1'b0, p[3], 1'b0} + {2'b00, p[6]};
        py_d = {2'b00, p[6]} + {1'b0, p[7], 1'b0} + {2'b00, p[8]};
        ny_d = {2'b00, p[0]} + {1'b0, p[1], 1'b0} + {2'b00, p[2]};
    end

    // Stage 2: |g| never exceeds 1020, so a 10-bit two's-complement negate is exact
    always_comb begin
        gx   = $signed({1'b0, px_q}) - $signed({1'b0, nx_q});
        gy   = $signed({1'b0, py_q}) - $signed({1'b0, ny_q});
        ax_d = gx[10] ? (10'd0 - gx[9:0]) : gx[9:0];
        ay_d = gy[10] ? (10'd0 - gy[9:0]) : gy[9:0];
    end

    // Stage 3: mode and threshold are applied live to whichever pixel is here
    always_comb begin
        mag    = {1'b0, ax_q} + {1'b0, ay_q};
        sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
        result = sat;
        if (i_bin_en) begin
            result = (sat > i_threshold) ? 8'hFF : 8'h00;
        end
    end

    // NOTE: all state uses non-blocking assignments so every stage samples the previous cycle's values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            px_q     <= '0;
            nx_q     <= '0;
            py_q     <= '0;
            ny_q     <= '0;
            ax_q     <= '0;
            ay_q     <= '0;
            valid_sr <= '0;
        end else begin
            px_q     <= px_d;
            nx_q     <= nx_d;
            py_q     <= py_d;
            ny_q     <= ny_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            valid_sr <= {valid_sr[0], i_pixel_data_valid};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_convolved_data       <= '0;
            o_convolved_data_valid <= 1'b0;
            o_line_done            <= 1'b0;
            col_cnt                <= '0;
        end else begin
            o_convolved_data_valid <= valid_sr[1];
            o_line_done            <= 1'b0;
            if (valid_sr[1]) begin
                o_convolved_data <= result;
                if (col_cnt == LAST_COL) begin
                    col_cnt     <= '0;
                    o_line_done <= 1'b1;
                end else begin
                    col_cnt <= col_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_conv.sv
// Self-checking bench for sobel_conv: directed windows, gapped streams, async reset and
// random windows compared cycle by cycle against a kernel-based reference model.
module tb_sobel_conv;

    localparam int LINE_PIXELS = 512;
    localparam int KX [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int KY [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [71:0] i_pixel_data = '0;
    logic        i_pixel_data_valid = 1'b0;
    logic        i_bin_en = 1'b0;
    logic [7:0]  i_threshold = '0;
    logic [7:0]  o_convolved_data;
    logic        o_convolved_data_valid;
    logic        o_line_done;

    sobel_conv #(.LINE_PIXELS(LINE_PIXELS), .CNT_W(9)) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_pixel_data           (i_pixel_data),
        .i_pixel_data_valid     (i_pixel_data_valid),
        .i_bin_en               (i_bin_en),
        .i_threshold            (i_threshold),
        .o_convolved_data       (o_convolved_data),
        .o_convolved_data_valid (o_convolved_data_valid),
        .o_line_done            (o_line_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          valid;
        logic [71:0] win;
    } rec_t;

    rec_t       pend [$];
    int         total = 0;
    int         bad = 0;
    int         out_cnt = 0;
    int         valid_seen = 0;
    int         ld_seen = 0;
    logic [7:0] exp_data = '0;
    string      phase = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s [%s] t=%0t got=%0h expected=%0h", tag, phase, $time, got, exp);
        end
    endtask

    function automatic int ref_pixel(input logic [71:0] w, input bit bin, input logic [7:0] thr);
        int gx = 0;
        int gy = 0;
        int mag;
        for (int k = 0; k < 9; k++) begin
            int pv = int'(w[8*k +: 8]);
            gx += KX[k] * pv;
            gy += KY[k] * pv;
        end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mag > 255) mag = 255;
        if (bin) return (mag > int'(thr)) ? 255 : 0;
        return mag;
    endfunction

    function automatic logic [71:0] by_cols(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = (k % 3 == 0) ? c0 : (k % 3 == 1) ? c1 : c2;
        end
        return w;
    endfunction

    function automatic logic [71:0] by_rows(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            w[8*k +: 8] = (k / 3 == 0) ? r0 : (k / 3 == 1) ? r1 : r2;
        end
        return w;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        case ($urandom_range(0, 3))
            0: w = {8'($urandom), 32'($urandom), 32'($urandom)};
            1: for (int k = 0; k < 9; k++) w[8*k +: 8] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            2: w = by_cols(8'($urandom_range(0, 1) * 255), 8'($urandom), 8'($urandom_range(0, 1) * 255));
            default: w = by_rows(8'($urandom_range(0, 1) * 255), 8'($urandom), 8'($urandom_range(0, 1) * 255));
        endcase
        return w;
    endfunction

    // One clock: drive inputs, then compare the outputs visible right after the edge
    task automatic step(input bit v, input logic [71:0] w, input bit bin, input logic [7:0] thr);
        rec_t r;
        rec_t o;
        bit   ev;
        bit   eld;
        i_pixel_data_valid = v;
        i_pixel_data       = w;
        i_bin_en           = bin;
        i_threshold        = thr;
        r.valid = v;
        r.win   = w;
        pend.push_back(r);
        @(posedge i_clk);
        #1;
        ev  = 1'b0;
        eld = 1'b0;
        if (pend.size() >= 3) begin
            o  = pend.pop_front();
            ev = o.valid;
            if (ev) begin
                out_cnt++;
                exp_data = 8'(ref_pixel(o.win, bin, thr));
                eld      = (out_cnt % LINE_PIXELS) == 0;
            end
        end
        valid_seen += int'(o_convolved_data_valid);
        ld_seen    += int'(o_line_done);
        check("valid", o_convolved_data_valid, ev);
        check("data", o_convolved_data, exp_data);
        check("line_done", o_line_done, eld);
    endtask

    task automatic flush(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 8'h00);
    endtask

    task automatic single(input string tag, input logic [71:0] w, input bit bin, input logic [7:0] thr,
                          input logic [7:0] exp);
        step(1'b1, w, bin, thr);
        step(1'b0, '0, bin, thr);
        step(1'b0, '0, bin, thr);
        check({tag, "_valid"}, o_convolved_data_valid, 1'b1);
        check(tag, o_convolved_data, exp);
        step(1'b0, '0, bin, thr);
    endtask

    task automatic apply_reset();
        i_rst              = 1'b1;
        i_pixel_data_valid = 1'b0;
        i_pixel_data       = '0;
        #1;
        check("rst_valid", o_convolved_data_valid, 1'b0);
        check("rst_data", o_convolved_data, 8'h00);
        check("rst_line_done", o_line_done, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_hold_valid", o_convolved_data_valid, 1'b0);
        check("rst_hold_data", o_convolved_data, 8'h00);
        @(negedge i_clk);
        i_rst = 1'b0;
        pend.delete();
        exp_data = '0;
        out_cnt  = 0;
    endtask

    initial begin
        int sent;
        int v0;
        int l0;

        phase = "reset";
        apply_reset();

        phase = "directed";
        single("flat", {9{8'h80}}, 1'b0, 8'h00, 8'h00);
        single("grad40", by_cols(8'h00, 8'h00, 8'h0A), 1'b0, 8'h00, 8'h28);
        single("sat_x", by_cols(8'h00, 8'h80, 8'hFF), 1'b0, 8'h00, 8'hFF);
        single("sat_y", by_rows(8'h00, 8'h80, 8'hFF), 1'b0, 8'h00, 8'hFF);
        single("bin_eq", by_cols(8'h00, 8'h00, 8'h0A), 1'b1, 8'h28, 8'h00);
        single("bin_gt", by_cols(8'h00, 8'h00, 8'h0A), 1'b1, 8'h27, 8'hFF);
        single("neg_x", by_cols(8'hFF, 8'h00, 8'h00), 1'b0, 8'h00, 8'hFF);
        single("small_neg", by_rows(8'h05, 8'h00, 8'h00), 1'b0, 8'h00, 8'h14);

        phase = "gaps";
        apply_reset();
        v0   = valid_seen;
        l0   = ld_seen;
        sent = 0;
        while (sent < 1024) begin
            bit v = $urandom_range(0, 99) >= 30;
            step(v, rand_win(), 1'b0, 8'h00);
            sent += int'(v);
        end
        flush(3);
        check("gap_outputs", 32'(valid_seen - v0), 32'd1024);
        check("gap_line_done", 32'(ld_seen - l0), 32'd2);

        phase = "wrap";
        l0 = ld_seen;
        for (int i = 0; i < LINE_PIXELS; i++) step(1'b1, rand_win(), 1'b0, 8'h00);
        flush(3);
        check("wrap_line_done", 32'(ld_seen - l0), 32'd1);

        phase = "async_rst";
        for (int i = 0; i < 5; i++) step(1'b1, by_cols(8'h00, 8'h00, 8'hFF), 1'b0, 8'h00);
        check("pre_rst_valid", o_convolved_data_valid, 1'b1);
        #3;
        apply_reset();
        v0 = valid_seen;
        flush(6);
        check("no_stale", 32'(valid_seen - v0), 32'd0);
        l0 = ld_seen;
        for (int i = 0; i < LINE_PIXELS - 1; i++) step(1'b1, rand_win(), 1'b0, 8'h00);
        flush(3);
        check("early_line_done", 32'(ld_seen - l0), 32'd0);
        step(1'b1, rand_win(), 1'b0, 8'h00);
        flush(3);
        check("post_rst_line_done", 32'(ld_seen - l0), 32'd1);

        phase = "random";
        step(1'b1, by_cols(8'hFF, 8'hFF, 8'h00), 1'b0, 8'h00);
        step(1'b1, by_rows(8'h00, 8'hFF, 8'hFF), 1'b0, 8'h00);
        step(1'b1, by_rows(8'hFF, 8'h00, 8'h00), 1'b1, 8'hFE);
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 9) != 0, rand_win(), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        flush(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
